// File: rtl/morse_keyer_if.sv
// morse_keyer_if -- code handshake between the keyboard decoder and the keyer.
//   code_in    : PS/2 make/break scan code
//   code_valid : code_in holds a code this cycle
//   ready      : keyer accepts a code on the next rising edge when both are high
// The master modport belongs to the decoder side, slave to the keyer.
interface morse_keyer_if;
  logic [7:0] code_in;
  logic       code_valid;
  logic       ready;

  modport master (output code_in, output code_valid, input ready);
  modport slave  (input code_in, input code_valid, output ready);
endinterface

// File: rtl/morse_keyer.sv
// morse_keyer -- turns accepted PS/2 scan codes into a keyed Morse line.
//
// Letters A-Z (and digits 0-9 when MORSE_DIGITS_EN is defined) are looked up
// in a pattern table and played out as marks and gaps timed in units of U
// clocks, where U is picked by `mode` at the moment the code is accepted.
// Enter (0x5A) plays a 7U word gap, 0xF0 arms a break flag that swallows the
// next accepted code, anything else raises a one-cycle err pulse.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   mode      : 0 = UNIT_FAST clocks per unit, 1 = UNIT_SLOW
//   code_if   : slave side of the code_in/code_valid/ready handshake
//   morse_out : keyed line, 1 = tone
//   busy      : a mark or gap is being timed
//   sym_done  : one-cycle pulse when a letter or word gap finishes
//   err       : one-cycle pulse after an unsupported code is accepted
//
// Build option: define MORSE_DIGITS_EN to add the digit patterns.
module morse_keyer #(
  parameter int unsigned UNIT_FAST = 4,
  parameter int unsigned UNIT_SLOW = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  morse_keyer_if.slave code_if,
  output logic         morse_out,
  output logic         busy,
  output logic         sym_done,
  output logic         err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MARK = 3'd1,
    ST_GAP  = 3'd2,
    ST_LGAP = 3'd3,
    ST_WGAP = 3'd4
  } state_t;

  localparam logic [7:0]       CODE_ENTER = 8'h5A;
  localparam logic [7:0]       CODE_BREAK = 8'hF0;
  localparam logic [CNT_W-1:0] U_FAST     = CNT_W'(UNIT_FAST);
  localparam logic [CNT_W-1:0] U_SLOW     = CNT_W'(UNIT_SLOW);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef MORSE_DIGITS_EN
  localparam bit DIGITS_EN = 1'b1;
`else
  localparam bit DIGITS_EN = 1'b0;
`endif

  // Table entries are {supported, length[2:0], pattern[4:0]}. The pattern is
  // left-aligned: bit 4 is the first symbol, 1 = dash, 0 = dot.
  function automatic logic [8:0] letter_entry(input logic [7:0] code);
    logic [8:0] e;
    e = 9'd0;
    case (code)
      8'h1C: e = {1'b1, 3'd2, 5'b01000}; // A .-
      8'h32: e = {1'b1, 3'd4, 5'b10000}; // B -...
      8'h21: e = {1'b1, 3'd4, 5'b10100}; // C -.-.
      8'h23: e = {1'b1, 3'd3, 5'b10000}; // D -..
      8'h24: e = {1'b1, 3'd1, 5'b00000}; // E .
      8'h2B: e = {1'b1, 3'd4, 5'b00100}; // F ..-.
      8'h34: e = {1'b1, 3'd3, 5'b11000}; // G --.
      8'h33: e = {1'b1, 3'd4, 5'b00000}; // H ....
      8'h43: e = {1'b1, 3'd2, 5'b00000}; // I ..
      8'h3B: e = {1'b1, 3'd4, 5'b01110}; // J .---
      8'h42: e = {1'b1, 3'd3, 5'b10100}; // K -.-
      8'h4B: e = {1'b1, 3'd4, 5'b01000}; // L .-..
      8'h3A: e = {1'b1, 3'd2, 5'b11000}; // M --
      8'h31: e = {1'b1, 3'd2, 5'b10000}; // N -.
      8'h44: e = {1'b1, 3'd3, 5'b11100}; // O ---
      8'h4D: e = {1'b1, 3'd4, 5'b01100}; // P .--.
      8'h15: e = {1'b1, 3'd4, 5'b11010}; // Q --.-
      8'h2D: e = {1'b1, 3'd3, 5'b01000}; // R .-.
      8'h1B: e = {1'b1, 3'd3, 5'b00000}; // S ...
      8'h2C: e = {1'b1, 3'd1, 5'b10000}; // T -
      8'h3C: e = {1'b1, 3'd3, 5'b00100}; // U ..-
      8'h2A: e = {1'b1, 3'd4, 5'b00010}; // V ...-
      8'h1D: e = {1'b1, 3'd3, 5'b01100}; // W .--
      8'h22: e = {1'b1, 3'd4, 5'b10010}; // X -..-
      8'h35: e = {1'b1, 3'd4, 5'b10110}; // Y -.--
      8'h1A: e = {1'b1, 3'd4, 5'b11000}; // Z --..
      default: e = 9'd0;
    endcase
    return e;
  endfunction

  function automatic logic [8:0] digit_entry(input logic [7:0] code);
    logic [8:0] e;
    e = 9'd0;
    case (code)
      8'h45: e = {1'b1, 3'd5, 5'b11111}; // 0
      8'h16: e = {1'b1, 3'd5, 5'b01111}; // 1
      8'h1E: e = {1'b1, 3'd5, 5'b00111}; // 2
      8'h26: e = {1'b1, 3'd5, 5'b00011}; // 3
      8'h25: e = {1'b1, 3'd5, 5'b00001}; // 4
      8'h2E: e = {1'b1, 3'd5, 5'b00000}; // 5
      8'h36: e = {1'b1, 3'd5, 5'b10000}; // 6
      8'h3D: e = {1'b1, 3'd5, 5'b11000}; // 7
      8'h3E: e = {1'b1, 3'd5, 5'b11100}; // 8
      8'h46: e = {1'b1, 3'd5, 5'b11110}; // 9
      default: e = 9'd0;
    endcase
    return e;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] u_r, u_s;
  logic [CNT_W-1:0] u3_s, u7_s, seg_last_s, unit_s;
  logic [4:0]       pat_r, pat_s;
  logic [2:0]       rem_r, rem_s;
  logic             brk_r, brk_s;
  logic             ready_r;
  logic             accept_s, err_s, done_s;
  logic [8:0]       ent_s;

  // Letter and digit scan codes never overlap, so the two tables can be OR-ed.
  assign ent_s    = letter_entry(code_if.code_in) |
                    (DIGITS_EN ? digit_entry(code_if.code_in) : 9'd0);
  assign accept_s = code_if.code_valid & ready_r;
  assign unit_s   = mode ? U_SLOW : U_FAST;
  assign u3_s     = (u_r << 1) + u_r;
  // 8U may overflow the counter width, but the modular subtraction still
  // yields 7U whenever 7U fits.
  assign u7_s     = (u_r << 3) - u_r;
  assign code_if.ready = ready_r;

  // Last counter value of the segment currently being timed.
  always_comb begin
    seg_last_s = CNT_ZERO;
    case (state_r)
      ST_MARK: seg_last_s = pat_r[4] ? (u3_s - CNT_ONE) : (u_r - CNT_ONE);
      ST_GAP:  seg_last_s = u_r - CNT_ONE;
      ST_LGAP: seg_last_s = u3_s - CNT_ONE;
      ST_WGAP: seg_last_s = u7_s - CNT_ONE;
      default: seg_last_s = CNT_ZERO;
    endcase
  end

  // Next-state, segment counter and pattern bookkeeping.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_ONE;
    u_s     = u_r;
    pat_s   = pat_r;
    rem_s   = rem_r;
    brk_s   = brk_r;
    err_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (accept_s) begin
          if (brk_r) begin
            // Code following a break prefix is a key release: drop it.
            brk_s = 1'b0;
          end else if (ent_s[8]) begin
            state_s = ST_MARK;
            u_s     = unit_s;
            rem_s   = ent_s[7:5];
            pat_s   = ent_s[4:0];
          end else if (code_if.code_in == CODE_ENTER) begin
            state_s = ST_WGAP;
            u_s     = unit_s;
          end else if (code_if.code_in == CODE_BREAK) begin
            brk_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          brk_s = brk_r;
        end
      end
      ST_MARK: begin
        if (cnt_r == seg_last_s) begin
          cnt_s = CNT_ZERO;
          if (rem_r > 3'd1) begin
            state_s = ST_GAP;
            pat_s   = {pat_r[3:0], 1'b0};
            rem_s   = rem_r - 3'd1;
          end else begin
            state_s = ST_LGAP;
          end
        end else begin
          state_s = ST_MARK;
        end
      end
      ST_GAP: begin
        if (cnt_r == seg_last_s) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_MARK;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_LGAP, ST_WGAP: begin
        if (cnt_r == seg_last_s) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      u_r     <= U_FAST;
      pat_r   <= 5'd0;
      rem_r   <= 3'd0;
      brk_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      u_r     <= u_s;
      pat_r   <= pat_s;
      rem_r   <= rem_s;
      brk_r   <= brk_s;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      morse_out <= 1'b0;
      busy      <= 1'b0;
      ready_r   <= 1'b1;
      sym_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      morse_out <= (state_s == ST_MARK);
      busy      <= (state_s != ST_IDLE);
      ready_r   <= (state_s == ST_IDLE);
      sym_done  <= done_s;
      err       <= err_s;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer -- self-checking bench for morse_keyer.
// A reference model turns each accepted code into the expected per-cycle
// output vector {morse_out, busy, sym_done, err, ready} using the dot/dash
// strings of the Morse alphabet and the unit timing rules; every cycle the
// DUT outputs are compared against that queue. Directed scenarios come
// first, then randomized codes, modes and resets.
module tb_morse_keyer;
  localparam int UF = 4;
  localparam int US = 8;

  localparam logic [4:0] V_IDLE = 5'b00001;
  localparam logic [4:0] V_MARK = 5'b11000;
  localparam logic [4:0] V_GAP  = 5'b01000;
  localparam logic [4:0] V_DONE = 5'b00101;
  localparam logic [4:0] V_ERR  = 5'b00011;

  logic clk = 1'b0;
  logic rst_n;
  logic mode;
  logic morse_out, busy, sym_done, err;

  morse_keyer_if kif();

  morse_keyer #(.UNIT_FAST(UF), .UNIT_SLOW(US), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .code_if   (kif),
    .morse_out (morse_out),
    .busy      (busy),
    .sym_done  (sym_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned busy_cnt = 0, mark_cnt = 0, done_cnt = 0, errp_cnt = 0;
  int unsigned acc_cyc = 0;
  string       phase = "reset";
  string       mtab [logic [7:0]];
  logic [4:0]  exp_q [$];
  bit          brk = 1'b0;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                              8'h3D, 8'h3E, 8'h46};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic init_table();
    mtab[8'h1C] = ".-";   mtab[8'h32] = "-..."; mtab[8'h21] = "-.-."; mtab[8'h23] = "-..";
    mtab[8'h24] = ".";    mtab[8'h2B] = "..-."; mtab[8'h34] = "--.";  mtab[8'h33] = "....";
    mtab[8'h43] = "..";   mtab[8'h3B] = ".---"; mtab[8'h42] = "-.-";  mtab[8'h4B] = ".-..";
    mtab[8'h3A] = "--";   mtab[8'h31] = "-.";   mtab[8'h44] = "---";  mtab[8'h4D] = ".--.";
    mtab[8'h15] = "--.-"; mtab[8'h2D] = ".-.";  mtab[8'h1B] = "...";  mtab[8'h2C] = "-";
    mtab[8'h3C] = "..-";  mtab[8'h2A] = "...-"; mtab[8'h1D] = ".--";  mtab[8'h22] = "-..-";
    mtab[8'h35] = "-.--"; mtab[8'h1A] = "--..";
`ifdef MORSE_DIGITS_EN
    mtab[8'h45] = "-----"; mtab[8'h16] = ".----"; mtab[8'h1E] = "..---"; mtab[8'h26] = "...--";
    mtab[8'h25] = "....-"; mtab[8'h2E] = "....."; mtab[8'h36] = "-...."; mtab[8'h3D] = "--...";
    mtab[8'h3E] = "---.."; mtab[8'h46] = "----.";
`endif
  endtask

  // Append the expected output vectors that follow acceptance of code c.
  task automatic model_accept(input logic [7:0] c, input logic m);
    int    u;
    string s;
    u = m ? US : UF;
    if (brk) begin
      brk = 1'b0;
      exp_q.push_back(V_IDLE);
    end else if (mtab.exists(c)) begin
      s = mtab[c];
      for (int i = 0; i < s.len(); i++) begin
        repeat ((s[i] == "-") ? 3 * u : u) exp_q.push_back(V_MARK);
        if (i != s.len() - 1) repeat (u) exp_q.push_back(V_GAP);
      end
      repeat (3 * u) exp_q.push_back(V_GAP);
      exp_q.push_back(V_DONE);
    end else if (c == 8'h5A) begin
      repeat (7 * u) exp_q.push_back(V_GAP);
      exp_q.push_back(V_DONE);
    end else if (c == 8'hF0) begin
      brk = 1'b1;
      exp_q.push_back(V_IDLE);
    end else begin
      exp_q.push_back(V_ERR);
    end
  endtask

  // One clock: check this cycle's outputs, then drive inputs for the next edge.
  task automatic tick(input logic v, input logic [7:0] c, input logic m, input logic rn,
                      output bit acc);
    logic [4:0] exp_v;
    logic [4:0] obs;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    else exp_v = V_IDLE;
    obs = {morse_out, busy, sym_done, err, kif.ready};
    check_eq(phase, 32'(obs), 32'(exp_v));
    if (busy === 1'b1) busy_cnt++;
    if (morse_out === 1'b1) mark_cnt++;
    if (sym_done === 1'b1) done_cnt++;
    if (err === 1'b1) errp_cnt++;
    kif.code_valid = v;
    kif.code_in    = c;
    mode           = m;
    rst_n          = rn;
    acc            = 1'b0;
    if (!rn) begin
      exp_q.delete();
      brk = 1'b0;
    end else if (v && exp_v[0]) begin
      acc     = 1'b1;
      acc_cyc = cyc;
      model_accept(c, m);
    end
  endtask

  // Hold code_valid until the code is taken; junk on other cycles must be ignored.
  task automatic send(input logic [7:0] c, input logic m);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 300 && !acc; k++) tick(1'b1, c, m, 1'b1, acc);
    if (!acc) check_eq("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 1000 && exp_q.size() > 0; k++)
      tick(1'b0, 8'($urandom), 1'($urandom), 1'b1, acc);
  endtask

  task automatic clear_counts();
    busy_cnt = 0; mark_cnt = 0; done_cnt = 0; errp_cnt = 0;
  endtask

  initial begin
    bit          acc;
    int unsigned a_cyc;
    logic [7:0]  c;
    int unsigned r;

    init_table();
    rst_n          = 1'b0;
    mode           = 1'b0;
    kif.code_valid = 1'b0;
    kif.code_in    = 8'h00;
    repeat (2) @(posedge clk);

    phase = "reset";
    tick(1'b0, 8'h00, 1'b0, 1'b1, acc);

    phase = "E_fast";
    clear_counts();
    send(8'h24, 1'b0);
    drain();
    check_eq("E_busy", busy_cnt, 32'd16);
    check_eq("E_mark", mark_cnt, 32'd4);
    check_eq("E_done", done_cnt, 32'd1);

    phase = "A_b2b";
    clear_counts();
    send(8'h1C, 1'b0);
    a_cyc = acc_cyc;
    send(8'h24, 1'b0);
    check_eq("A_b2b_gap", acc_cyc - a_cyc, 32'd33);
    drain();
    check_eq("A_E_busy", busy_cnt, 32'd48);
    check_eq("A_E_mark", mark_cnt, 32'd20);

    phase = "wgap_T_slow";
    clear_counts();
    send(8'h5A, 1'b1);
    send(8'h2C, 1'b1);
    drain();
    check_eq("WT_busy", busy_cnt, 32'd104);
    check_eq("WT_mark", mark_cnt, 32'd24);
    check_eq("WT_done", done_cnt, 32'd2);

    phase = "break";
    clear_counts();
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    drain();
    tick(1'b0, 8'h00, 1'b0, 1'b1, acc);
    check_eq("brk_mark", mark_cnt, 32'd0);
    check_eq("brk_err", errp_cnt, 32'd0);
    send(8'h1C, 1'b0);
    drain();
    check_eq("brk_then_A_mark", mark_cnt, 32'd16);

    phase = "unknown";
    clear_counts();
    send(8'h00, 1'b0);
    drain();
    check_eq("unk_err", errp_cnt, 32'd1);
    send(8'h16, 1'b0);
    drain();
`ifdef MORSE_DIGITS_EN
    check_eq("digit1_mark", mark_cnt, 32'd52);
`else
    check_eq("digit1_err", errp_cnt, 32'd2);
`endif

    phase = "reset_mid";
    clear_counts();
    send(8'h15, 1'b0);
    repeat (6) tick(1'b0, 8'h00, 1'b0, 1'b1, acc);
    tick(1'b1, 8'h24, 1'b0, 1'b0, acc);
    tick(1'b0, 8'h00, 1'b0, 1'b1, acc);
    tick(1'b0, 8'h00, 1'b0, 1'b1, acc);
    check_eq("rst_mid_done", done_cnt, 32'd0);
    clear_counts();
    send(8'h24, 1'b0);
    drain();
    check_eq("after_rst_E_mark", mark_cnt, 32'd4);

    phase = "random";
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) c = letters[$urandom_range(0, 25)];
      else if (r == 6) c = 8'h5A;
      else if (r == 7) c = 8'hF0;
      else if (r == 8) c = digits[$urandom_range(0, 9)];
      else c = 8'($urandom);
      send(c, 1'($urandom));
      repeat ($urandom_range(0, 5)) tick(1'($urandom), 8'($urandom), 1'($urandom), 1'b1, acc);
      if ($urandom_range(0, 9) == 0) tick(1'($urandom), 8'($urandom), 1'($urandom), 1'b0, acc);
    end
    drain();
    tick(1'b0, 8'h00, 1'b0, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Successor to the combinational scan-code-to-Morse lookup.
- Accepts PS/2 make codes over a valid/ready handshake and maps letters (and optionally digits) to Morse patterns.
- Serialises each pattern onto a single on/off line with programmable unit timing: dot, dash, intra-symbol, letter and word gaps.
- Sits between the keyboard decoder and the LED/buzzer driver. The `mode` input (solo/multiplayer) selects the unit length.

Parameters:
- UNIT_FAST, 4, clocks per Morse unit when mode=0 (must be >=1)
- UNIT_SLOW, 8, clocks per Morse unit when mode=1 (must be >=1)
- CNT_W, 16, width of the unit-timing counter; must hold 7*max(UNIT_FAST,UNIT_SLOW)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- mode  in  1  0=soloplayer (UNIT_FAST), 1=multiplayer (UNIT_SLOW)
- code_in  in  8  PS/2 scan code
- code_valid  in  1  code_in valid this cycle
- ready  out  1  block can accept a code this cycle
- morse_out  out  1  keyed Morse line, 1=tone/mark
- busy  out  1  high while any mark or gap is being timed
- sym_done  out  1  one-cycle pulse when a character or word gap completes
- err  out  1  one-cycle pulse when an accepted code is unsupported

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All outputs are registered.
- Reset state:
  - State = IDLE.
  - morse_out=0, busy=0, sym_done=0, err=0, ready=1 (from the first clock after rst_n rises).
  - Break flag cleared.
- Reset mid-operation: on the next edge, force IDLE, drop morse_out and abort the pattern. No sym_done.
- Handshake:
  - A code is accepted on a rising edge where code_valid=1 and ready=1.
  - ready=1 only in IDLE. code_in is ignored when not accepted.
- mode is sampled at acceptance; U = mode ? UNIT_SLOW : UNIT_FAST. U is held for the whole character.
- Pattern table:
  - Internally a length (1..5) plus a bit vector, sent MSB first; 1=dash, 0=dot.
  - Letters A–Z use the standard Morse code. Scan codes: q15 w1D e24 r2D t2C y35 u3C i43 o44 p4D a1C s1B d23 f2B g34 h33 j3B k42 l4B z1A x22 c21 v2A b32 n31 m3A.
- States:
  - IDLE:
    - Accept letter -> MARK; morse_out=1 from the accepting edge.
    - Accept 0x5A (Enter) -> WGAP.
    - Accept 0xF0 -> set break flag, stay IDLE.
    - Accept any other code -> err pulse on the next cycle, stay IDLE.
  - Break flag: if set, the next accepted code of any value is discarded silently (no output, no err) and the flag clears.
  - MARK:
    - morse_out=1 for U cycles (dot) or 3U cycles (dash).
    - Then GAP if symbols remain, else LGAP.
  - GAP: morse_out=0 for U cycles -> MARK with the next symbol.
  - LGAP: morse_out=0 for 3U cycles -> IDLE. sym_done=1 on the cycle IDLE is re-entered.
  - WGAP: morse_out=0 for 7U cycles -> IDLE with sym_done pulse.
- busy = (state != IDLE).
- Counter: counts 0..N-1 per segment and resets at each segment boundary. No wrap beyond N-1.
- Total busy cycles for a character = sum(marks) + U*(len-1) + 3U.
- Timing: the cycle that re-enters IDLE has ready=1, so back-to-back codes start with no extra idle cycle.

Optional Feature:
- MORSE_DIGITS_EN defined:
  - Digit scan codes 45(0) 16(1) 1E(2) 26(3) 25(4) 2E(5) 36(6) 3D(7) 3E(8) 46(9) map to standard 5-symbol Morse digits.
  - The table length field is 3 bits.
- Undefined: those codes are unsupported and raise err like any other unknown code.

Test Plan:
- mode=0, UNIT_FAST=4, send 0x24 ('E') -> morse_out high 4 cycles, low 12; sym_done pulse at cycle 16; busy high 16 cycles.
- mode=0, send 0x1C ('A') -> high 4, low 4, high 12, low 12; total 32 busy cycles. A second code presented the cycle ready rises is accepted immediately.
- mode=1, UNIT_SLOW=8, send 0x5A -> morse_out stays 0, busy high 56 cycles, one sym_done. Then send 0x2C ('T') -> high 24, low 24.
- Send 0xF0, then 0x1C -> no morse_out activity, no err. Then send 0x1C -> normal 'A' waveform.
- Send 0x00 -> err pulse exactly 1 cycle, ready stays 1, morse_out 0. Send 0x16 -> err without MORSE_DIGITS_EN. With it: 1 dot then 4 dashes (high 4, low 4, then 4× high 12 separated by low 4).
- Send 0x15 ('Q'), assert rst_n=0 for one edge during the first dash -> morse_out 0 and ready 1 next cycle, no sym_done. The next code behaves normally.
